pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage_pkg.sv | 13 +
 rtl/pipe_entry_reg.sv | 28 ++
 rtl/pipe_skid_stage.sv | 116 +++++++++++
 tb/tb_pipe_skid_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// Shared types for the two-entry pipeline skid stage: occupancy state encoding and default payload width.
package pipe_skid_stage_pkg;

   localparam int DEFAULT_DATA_W = 48;

   // Encoding doubles as the occupancy count driven on the output port.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload slot: async-reset register with synchronous clear (priority) and write enable.
// Single-cycle write, no handshake; the owning stage decides when to load or clear.
module pipe_entry_reg #(
   parameter int DATA_W = 48
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_we,
   input  logic [DATA_W-1:0] i_d,
   output logic [DATA_W-1:0] o_q
);

   logic [DATA_W-1:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_clr) begin
         r_q <= '0;
      end else if (i_we) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready skid stage with halt latch and flush; head visible one edge after push into an empty stage.
// in_ready comes only from registered state and flush, so downstream stalls are absorbed by the skid entry.
module pipe_skid_stage
   import pipe_skid_stage_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int HALT_BIT = DATA_W - 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              halted,
   output logic [1:0]        occupancy
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_halted;
   logic              w_push;
   logic              w_pop;
   logic              w_head_we;
   logic              w_skid_we;
   logic [DATA_W-1:0] w_head_d;
   logic [DATA_W-1:0] w_head_q;
   logic [DATA_W-1:0] w_skid_q;

   // rst_n gates in_ready so nothing is offered acceptance while reset is held.
   assign in_ready  = rst_n && !flush && !r_halted && (r_state != ST_FULL);
   assign out_valid = !flush && (r_state != ST_EMPTY);
   assign out_data  = (r_state == ST_EMPTY) ? '0 : w_head_q;
   assign halted    = r_halted;
   assign occupancy = r_state;

   assign w_push = in_valid && in_ready;
   assign w_pop  = out_valid && out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_head_we   = 1'b0;
      w_skid_we   = 1'b0;
      w_head_d    = in_data;
      case (r_state)
         ST_EMPTY: begin
            if (w_push) begin
               w_state_nxt = ST_ONE;
               w_head_we   = 1'b1;
            end
         end
         ST_ONE: begin
            if (w_push && w_pop) begin
               w_head_we = 1'b1;
            end else if (w_push) begin
               w_state_nxt = ST_FULL;
               w_skid_we   = 1'b1;
            end else if (w_pop) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_pop) begin
               w_state_nxt = ST_ONE;
               w_head_we   = 1'b1;
               w_head_d    = w_skid_q;
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else if (flush) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_halted <= 1'b0;
      end else if (flush) begin
         r_halted <= 1'b0;
      end else if (w_push && in_data[HALT_BIT]) begin
         r_halted <= 1'b1;
      end
   end

   pipe_entry_reg #(.DATA_W(DATA_W)) u_head (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (flush),
      .i_we  (w_head_we),
      .i_d   (w_head_d),
      .o_q   (w_head_q)
   );

   pipe_entry_reg #(.DATA_W(DATA_W)) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (flush),
      .i_we  (w_skid_we),
      .i_d   (in_data),
      .o_q   (w_skid_q)
   );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: scenario tasks plus a FIFO scoreboard fed on model-predicted accepts.
module tb_pipe_skid_stage;

   localparam int DW = 48;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic          halted;
   logic [1:0]    occupancy;

   int            n_checks;
   int            n_errors;
   logic [DW-1:0] sb[$];
   logic          m_halted;

   pipe_skid_stage #(.DATA_W(DW), .HALT_BIT(DW-1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .halted    (halted),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle: drive at negedge, check against the model before the next posedge, advance the model.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy,
                       input logic fl, output logic acc);
      logic exp_ir;
      logic exp_ov;
      logic [DW-1:0] exp_d;
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      #1;
      exp_ir = !fl && !m_halted && (sb.size() < 2);
      exp_ov = !fl && (sb.size() != 0);
      n_checks++;
      if (in_ready !== exp_ir) begin
         n_errors++;
         $display("FAIL step_in_ready: got %b expected %b at %0t", in_ready, exp_ir, $time);
      end
      n_checks++;
      if (out_valid !== exp_ov) begin
         n_errors++;
         $display("FAIL step_out_valid: got %b expected %b at %0t", out_valid, exp_ov, $time);
      end
      n_checks++;
      if (occupancy !== 2'(sb.size())) begin
         n_errors++;
         $display("FAIL step_occupancy: got %0d expected %0d at %0t", occupancy, sb.size(), $time);
      end
      if (sb.size() == 0 && !fl) begin
         n_checks++;
         if (out_data !== '0) begin
            n_errors++;
            $display("FAIL step_empty_data: got %h expected 0 at %0t", out_data, $time);
         end
      end
      if (exp_ov && ordy) begin
         exp_d = sb.pop_front();
         n_checks++;
         if (out_data !== exp_d) begin
            n_errors++;
            $display("FAIL step_out_data: got %h expected %h at %0t", out_data, exp_d, $time);
         end
      end
      acc = v && exp_ir;
      if (acc) begin
         sb.push_back(d);
         if (d[DW-1]) m_halted = 1'b1;
      end
      if (fl) begin
         sb.delete();
         m_halted = 1'b0;
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int max_cycles);
      logic acc;
      for (int i = 0; i < max_cycles && sb.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0, acc);
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL drain_timeout: got %0d entries left expected 0", sb.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      sb.delete(); m_halted = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++;
      if (out_data !== '0) begin n_errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
      n_checks++;
      if (occupancy !== 2'd0) begin n_errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
      n_checks++;
      if (halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_streaming();
      logic acc;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, DW'(i + 1), 1'b1, 1'b0, acc);
         if (i > 0) begin
            n_checks++;
            if (occupancy !== 2'd1) begin
               n_errors++;
               $display("FAIL stream_occupancy: got %0d expected 1 (beat %0d)", occupancy, i);
            end
            n_checks++;
            if (out_data !== DW'(i)) begin
               n_errors++;
               $display("FAIL stream_data: got %h expected %h", out_data, DW'(i));
            end
         end
      end
      step(1'b0, '0, 1'b1, 1'b0, acc);
      n_checks++;
      if (out_data !== DW'(8)) begin n_errors++; $display("FAIL stream_last: got %h expected 8", out_data); end
      drain(4);
   endtask

   task automatic test_backpressure();
      logic acc;
      int   cnt;
      step(1'b1, 48'hA, 1'b0, 1'b0, acc);
      step(1'b1, 48'hB, 1'b0, 1'b0, acc);
      step(1'b1, 48'hC, 1'b0, 1'b0, acc);
      n_checks++;
      if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); end
      acc = 1'b0;
      cnt = 0;
      while (!acc && cnt < 10) begin
         step(1'b1, 48'hC, 1'b1, 1'b0, acc);
         cnt++;
      end
      n_checks++;
      if (!acc) begin n_errors++; $display("FAIL bp_c_accept: got no accept expected accept within 10 cycles"); end
      drain(6);
   endtask

   task automatic test_halt();
      logic acc;
      step(1'b1, 48'h5, 1'b0, 1'b0, acc);
      step(1'b1, 48'h800000000007, 1'b0, 1'b0, acc);
      step(1'b1, 48'h9, 1'b0, 1'b0, acc);
      n_checks++;
      if (halted !== 1'b1) begin n_errors++; $display("FAIL halt_set: got %b expected 1", halted); end
      for (int i = 0; i < 4; i++) step(1'b1, 48'h9, 1'b1, 1'b0, acc);
      n_checks++;
      if (sb.size() != 0) begin n_errors++; $display("FAIL halt_drain: got %0d left expected 0", sb.size()); end
      n_checks++;
      if (halted !== 1'b1 || in_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL halt_hold: got halted=%b in_ready=%b expected 1/0", halted, in_ready);
      end
      step(1'b0, '0, 1'b0, 1'b1, acc);
      settle();
      n_checks++;
      if (halted !== 1'b0) begin n_errors++; $display("FAIL halt_flush_clear: got %b expected 0", halted); end
      step(1'b1, 48'h9, 1'b0, 1'b0, acc);
      n_checks++;
      if (!acc || in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL halt_resume: got in_ready=%b expected 1", in_ready);
      end
      drain(4);
   endtask

   task automatic test_flush_collision();
      logic acc;
      step(1'b1, 48'h1, 1'b0, 1'b0, acc);
      step(1'b1, 48'h2, 1'b0, 1'b0, acc);
      step(1'b1, 48'h3, 1'b1, 1'b1, acc);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL flush_hs: got in_ready=%b out_valid=%b expected 0/0", in_ready, out_valid);
      end
      step(1'b0, '0, 1'b1, 1'b0, acc);
      n_checks++;
      if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL flush_after: got occ=%0d out_valid=%b expected 0/0", occupancy, out_valid);
      end
   endtask

   task automatic test_reset_midop();
      logic acc;
      step(1'b1, 48'h11, 1'b0, 1'b0, acc);
      step(1'b1, 48'h22, 1'b0, 1'b0, acc);
      settle();
      n_checks++;
      if (occupancy !== 2'd2) begin n_errors++; $display("FAIL rstmid_pre: got %0d expected 2", occupancy); end
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (occupancy !== 2'd0) begin n_errors++; $display("FAIL rstmid_occ: got %0d expected 0", occupancy); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
      n_checks++;
      if (out_data !== '0) begin n_errors++; $display("FAIL rstmid_data: got %h expected 0", out_data); end
      sb.delete();
      m_halted = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 48'h33, 1'b1, 1'b0, acc);
      n_checks++;
      if (!acc) begin n_errors++; $display("FAIL rstmid_first_ready: got %b expected 1", in_ready); end
      drain(4);
   endtask

   task automatic test_random();
      logic          acc;
      logic [DW-1:0] rd;
      for (int i = 0; i < 10000; i++) begin
         rd = {16'($urandom), 32'($urandom)};
         rd[DW-1] = ($urandom_range(0, 63) == 0);
         step(($urandom_range(0, 3) != 0), rd, ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 99) == 0), acc);
         n_checks++;
         if (occupancy > 2'd2) begin
            n_errors++;
            $display("FAIL rand_occ_bound: got %0d expected <=2", occupancy);
         end
      end
      step(1'b0, '0, 1'b0, 1'b1, acc);
      drain(4);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_halt();
      test_flush_collision();
      test_reset_midop();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
